// File: rtl/game_pkg.sv
// Shared constants, FSM state codes and small helpers for the game datapath blocks.
package game_pkg;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned LANE_W    = 4;
  localparam int unsigned SCORE_W   = 8;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SCAN = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every cycle, loads SEED on reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= SEED;
    end else begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: rtl/enemy_wave_controller.sv
// Enemy lane state: kills from shots, periodic advance scan with collision reporting,
// and random spawning into one of 16 lanes.
module enemy_wave_controller
  import game_pkg::*;
#(
  parameter int unsigned MOVE_PERIOD  = 2500000,
  parameter int unsigned SPAWN_PERIOD = 25000000,
  parameter int unsigned DIST_W       = 8,
  parameter int unsigned DIST_MAX     = 200,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          firing,
  input  logic [NUM_LANES-1:0]          angles_hit,
  input  logic                          game_over,
  output logic                          collision,
  output logic [NUM_LANES-1:0]          enemy_active,
  output logic [NUM_LANES*DIST_W-1:0]   enemy_dist,
  output logic [SCORE_W-1:0]            score
);

  localparam int unsigned MOVE_CW  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int unsigned SPAWN_CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [MOVE_CW-1:0]  MOVE_LAST  = MOVE_CW'(MOVE_PERIOD - 1);
  localparam logic [SPAWN_CW-1:0] SPAWN_LAST = SPAWN_CW'(SPAWN_PERIOD - 1);
  localparam logic [DIST_W-1:0]   DIST_INIT  = DIST_W'(DIST_MAX);
  localparam logic [DIST_W-1:0]   DIST_ONE   = DIST_W'(1);
  localparam logic [LANE_W-1:0]   LANE_LAST  = LANE_W'(NUM_LANES - 1);

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     idx_q, idx_d;
  logic [MOVE_CW-1:0]    move_cnt_q, move_cnt_d;
  logic [SPAWN_CW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic                  move_pend_q, move_pend_d;
  logic                  spawn_pend_q, spawn_pend_d;
  logic [NUM_LANES-1:0]  active_q, active_d;
  logic [DIST_W-1:0]     dist_q [NUM_LANES];
  logic [DIST_W-1:0]     dist_d [NUM_LANES];
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  collision_q, collision_d;

  logic [15:0]           lfsr;
  logic                  lfsr_unused;
  logic [LANE_W-1:0]     spawn_lane_c;
  logic [NUM_LANES-1:0]  kill_c;
  logic [4:0]            kill_cnt_c;
  logic [SCORE_W:0]      score_sum_c;
  logic                  move_tick_c, spawn_tick_c;
  logic                  move_clr_c, spawn_clr_c;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  // Only the low nibble selects a lane; upper bits are left for other consumers.
  assign spawn_lane_c = lfsr[LANE_W-1:0];
  assign lfsr_unused  = ^lfsr[15:LANE_W];

  assign collision    = collision_q;
  assign enemy_active = active_q;
  assign score        = score_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_dist
    assign enemy_dist[g*DIST_W +: DIST_W] = dist_q[g];
  end

  // Next-state: kills first, then the FSM acts on the post-kill view of each lane.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    move_cnt_d   = move_cnt_q;
    spawn_cnt_d  = spawn_cnt_q;
    active_d     = active_q;
    dist_d       = dist_q;
    collision_d  = 1'b0;
    move_tick_c  = 1'b0;
    spawn_tick_c = 1'b0;
    move_clr_c   = 1'b0;
    spawn_clr_c  = 1'b0;

    kill_c      = (firing && !game_over) ? (angles_hit & active_q) : '0;
    kill_cnt_c  = popcount16(kill_c);
    score_sum_c = {1'b0, score_q} + (SCORE_W + 1)'(kill_cnt_c);
    score_d     = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];

    for (int i = 0; i < NUM_LANES; i++) begin
      if (kill_c[i]) begin
        active_d[i] = 1'b0;
        dist_d[i]   = '0;
      end
    end

    if (!game_over) begin
      if (move_cnt_q == MOVE_LAST) begin
        move_cnt_d  = '0;
        move_tick_c = 1'b1;
      end else begin
        move_cnt_d = move_cnt_q + MOVE_CW'(1);
      end
      if (spawn_cnt_q == SPAWN_LAST) begin
        spawn_cnt_d  = '0;
        spawn_tick_c = 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q + SPAWN_CW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!game_over) begin
          if (move_pend_q) begin
            move_clr_c = 1'b1;
            idx_d      = '0;
            state_d    = ST_SCAN;
          end else if (spawn_pend_q) begin
            spawn_clr_c = 1'b1;
            if (!active_q[spawn_lane_c] && !kill_c[spawn_lane_c]) begin
              active_d[spawn_lane_c] = 1'b1;
              dist_d[spawn_lane_c]   = DIST_INIT;
            end
          end
        end
      end
      ST_SCAN: begin
        if (active_q[idx_q] && !kill_c[idx_q]) begin
          if (dist_q[idx_q] == DIST_ONE) begin
            active_d[idx_q] = 1'b0;
            dist_d[idx_q]   = '0;
            collision_d     = 1'b1;
          end else begin
            dist_d[idx_q] = dist_q[idx_q] - DIST_ONE;
          end
        end
        if (idx_q == LANE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + LANE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick in the same cycle as the clear re-arms the flag.
    move_pend_d  = move_tick_c  | (move_pend_q  & ~move_clr_c);
    spawn_pend_d = spawn_tick_c | (spawn_pend_q & ~spawn_clr_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      move_cnt_q   <= '0;
      spawn_cnt_q  <= '0;
      move_pend_q  <= 1'b0;
      spawn_pend_q <= 1'b0;
      active_q     <= '0;
      dist_q       <= '{default: '0};
      score_q      <= '0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      move_cnt_q   <= move_cnt_d;
      spawn_cnt_q  <= spawn_cnt_d;
      move_pend_q  <= move_pend_d;
      spawn_pend_q <= spawn_pend_d;
      active_q     <= active_d;
      dist_q       <= dist_d;
      score_q      <= score_d;
      collision_q  <= collision_d;
    end
  end

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Randomized bench: a lane-level behavioural model is stepped alongside the DUT and
// all outputs are compared every cycle, plus literal checks after each reset.
module tb_enemy_wave_controller;

  localparam int MP    = 20;
  localparam int SP    = 7;
  localparam int DW    = 8;
  localparam int DMAX  = 3;
  localparam int NCYC  = 20000;

  logic          clk;
  logic          rst_n;
  logic          firing;
  logic [15:0]   angles_hit;
  logic          game_over;
  logic          collision;
  logic [15:0]   enemy_active;
  logic [16*DW-1:0] enemy_dist;
  logic [7:0]    score;

  enemy_wave_controller #(
    .MOVE_PERIOD  (MP),
    .SPAWN_PERIOD (SP),
    .DIST_W       (DW),
    .DIST_MAX     (DMAX),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .firing       (firing),
    .angles_hit   (angles_hit),
    .game_over    (game_over),
    .collision    (collision),
    .enemy_active (enemy_active),
    .enemy_dist   (enemy_dist),
    .score        (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Behavioural model: lanes as plain arrays, scan position as an int (-1 when idle),
  // tick timers as countdowns of remaining running cycles.
  int          m_dist [16];
  bit          m_act  [16];
  int          m_score;
  int          m_scan;
  bit          m_mpend;
  bit          m_spend;
  int          m_mleft;
  int          m_sleft;
  bit [15:0]   m_lfsr;
  bit          m_coll;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_dist[i] = 0;
      m_act[i]  = 1'b0;
    end
    m_score = 0;
    m_scan  = -1;
    m_mpend = 1'b0;
    m_spend = 1'b0;
    m_mleft = MP;
    m_sleft = SP;
    m_lfsr  = 16'hACE1;
    m_coll  = 1'b0;
  endtask

  task automatic model_step(input bit f, input bit [15:0] ah, input bit go);
    bit was_act [16];
    bit killed  [16];
    int nk;
    int lane;
    bit [3:0] nib;
    nk = 0;
    for (int i = 0; i < 16; i++) begin
      was_act[i] = m_act[i];
      killed[i]  = f && !go && m_act[i] && ah[i];
      if (killed[i]) begin
        m_act[i]  = 1'b0;
        m_dist[i] = 0;
        nk++;
      end
    end
    m_score = (m_score + nk > 255) ? 255 : m_score + nk;
    m_coll  = 1'b0;
    if (m_scan >= 0) begin
      lane = m_scan;
      if (was_act[lane] && !killed[lane]) begin
        if (m_dist[lane] == 1) begin
          m_act[lane]  = 1'b0;
          m_dist[lane] = 0;
          m_coll       = 1'b1;
        end else begin
          m_dist[lane] = m_dist[lane] - 1;
        end
      end
      m_scan = (lane == 15) ? -1 : lane + 1;
    end else if (!go) begin
      if (m_mpend) begin
        m_mpend = 1'b0;
        m_scan  = 0;
      end else if (m_spend) begin
        m_spend = 1'b0;
        nib  = m_lfsr[3:0];
        lane = int'(nib);
        if (!was_act[lane]) begin
          m_act[lane]  = 1'b1;
          m_dist[lane] = DMAX;
        end
      end
    end
    if (!go) begin
      m_mleft--;
      if (m_mleft == 0) begin
        m_mpend = 1'b1;
        m_mleft = MP;
      end
      m_sleft--;
      if (m_sleft == 0) begin
        m_spend = 1'b1;
        m_sleft = SP;
      end
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0]      exp_act;
    logic [16*DW-1:0] exp_dist;
    for (int i = 0; i < 16; i++) begin
      exp_act[i]           = m_act[i];
      exp_dist[i*DW +: DW] = DW'(m_dist[i]);
    end
    chk("collision", 128'(collision), 128'(m_coll));
    chk("enemy_active", 128'(enemy_active), 128'(exp_act));
    chk("enemy_dist", 128'(enemy_dist), 128'(exp_dist));
    chk("score", 128'(score), 128'(m_score));
  endtask

  int  edges;
  bit  rst_next;
  bit  f_in;
  bit  go_in;
  bit [15:0] ah_in;

  initial begin
    checks     = 0;
    failures   = 0;
    edges      = 0;
    rst_n      = 1'b0;
    firing     = 1'b0;
    angles_hit = '0;
    game_over  = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst_n) edges++;
      check_all();

      if (!rst_n) begin
        chk("rst_active", 128'(enemy_active), 128'h0);
        chk("rst_dist", 128'(enemy_dist), 128'h0);
        chk("rst_score", 128'(score), 128'h0);
        chk("rst_collision", 128'(collision), 128'h0);
      end else if (edges == 7) begin
        chk("pre_spawn_active", 128'(enemy_active), 128'h0);
      end else if (edges == 8) begin
        // Seed ACE1 stepped 7 times is ED89, so the first spawn lands in lane 9.
        chk("first_spawn_active", 128'(enemy_active), 128'h0200);
        chk("first_spawn_dist", 128'(enemy_dist[9*DW +: DW]), 128'd3);
      end

      rst_next = !((cyc < 4) || (cyc >= 9000 && cyc < 9004));
      if (!rst_next) begin
        rst_n      = 1'b0;
        firing     = 1'b0;
        angles_hit = '0;
        game_over  = 1'b0;
        model_reset();
      end else begin
        if (!rst_n) edges = 0;
        rst_n = 1'b1;
        if (edges < 10) begin
          f_in  = 1'b0;
          ah_in = '0;
          go_in = 1'b0;
        end else begin
          f_in  = ($urandom_range(0, 5) == 0);
          ah_in = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          go_in = ((cyc % 700) >= 400) && ((cyc % 700) < 520);
        end
        firing     = f_in;
        angles_hit = ah_in;
        game_over  = go_in;
        model_step(f_in, ah_in, go_in);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
